// File: rtl/piso_reg.sv
// Parallel-in serial-out driver for a 74HC595: shifts a WIDTH-bit word MSB first
// on a divided serial clock, pulses the storage latch, then enables the outputs.
module piso_reg #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 10
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [WIDTH-1:0] data,
  input  logic             write,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdo,
  output logic             latch,
  output logic             oe_n
);

  localparam int H  = CLK_DIV / 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (H > 1) ? $clog2(H) : 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("piso_reg: WIDTH must be >= 2");
    end
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("piso_reg: CLK_DIV must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tick_cnt, tick_cnt_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] buf_q, buf_nxt;
  logic             pending, pending_nxt;
  logic             sclk_nxt, sdo_nxt, latch_nxt, done_nxt, oe_n_nxt;
  logic             tick;

  assign tick = (tick_cnt == TW'(H - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    buf_nxt      = buf_q;
    pending_nxt  = pending;
    sclk_nxt     = sclk;
    sdo_nxt      = sdo;
    latch_nxt    = latch;
    done_nxt     = 1'b0;
    oe_n_nxt     = oe_n;

    // A write during a frame parks in the one-deep buffer; last write wins.
    if (write && state != IDLE) begin
      buf_nxt     = data;
      pending_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        sclk_nxt  = 1'b0;
        latch_nxt = 1'b0;
        if (write || pending) begin
          shreg_nxt    = write ? data : buf_q;
          sdo_nxt      = write ? data[WIDTH-1] : buf_q[WIDTH-1];
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          pending_nxt  = 1'b0;
          state_nxt    = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          tick_cnt_nxt = '0;
          sclk_nxt     = ~sclk;
          // Data only moves on the falling tick so it is stable around each rise.
          if (sclk) begin
            if (bit_cnt == CW'(WIDTH - 1)) begin
              state_nxt = LATCH;
              latch_nxt = 1'b1;
            end else begin
              shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
              sdo_nxt     = shreg[WIDTH-2];
              bit_cnt_nxt = bit_cnt + CW'(1);
            end
          end
        end else begin
          tick_cnt_nxt = tick_cnt + TW'(1);
        end
      end

      LATCH: begin
        if (tick) begin
          tick_cnt_nxt = '0;
          latch_nxt    = 1'b0;
          done_nxt     = 1'b1;
          oe_n_nxt     = 1'b0;
          state_nxt    = IDLE;
        end else begin
          tick_cnt_nxt = tick_cnt + TW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      buf_q    <= '0;
      pending  <= 1'b0;
      sclk     <= 1'b0;
      sdo      <= 1'b0;
      latch    <= 1'b0;
      done     <= 1'b0;
      oe_n     <= 1'b1;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      buf_q    <= buf_nxt;
      pending  <= pending_nxt;
      sclk     <= sclk_nxt;
      sdo      <= sdo_nxt;
      latch    <= latch_nxt;
      done     <= done_nxt;
      oe_n     <= oe_n_nxt;
    end
  end

endmodule

// File: doc/piso_reg.md
PISO_REG -- requirements
Module: piso_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per frame; legal range >= 2.
REQ-002 SHALL have parameter CLK_DIV, default 10: clk cycles per sclk period; even and >= 2; H = CLK_DIV/2 is the half-period.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port sclr, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port data, input, WIDTH: parallel word to send; MSB is shifted out first.
REQ-006 SHALL have port write, input, 1: one-cycle request; data is sampled on the same edge.
REQ-007 SHALL have port busy, output, 1: frame in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when a frame's latch phase completes.
REQ-009 SHALL have port sclk, output, 1: 74HC595 SHCP; the device samples sdo on the rising edge.
REQ-010 SHALL have port sdo, output, 1: 74HC595 DS.
REQ-011 SHALL have port latch, output, 1: 74HC595 STCP; the device outputs update on the rising edge.
REQ-012 SHALL have port oe_n, output, 1: 74HC595 OE#; high until the first frame is latched.

Function
REQ-013 SHALL implement states IDLE, SHIFT and LATCH, with a half-period tick counter and a bit counter of width GET_WIDTH(WIDTH).
REQ-014 SHALL, in IDLE on a cycle N with write=1 or pending=1: load the shift register from the buffer (write has priority over the buffer), set sdo to bit WIDTH-1, clear both counters and enter SHIFT at N+1.
REQ-015 SHALL, in SHIFT, produce one tick every H cycles counted from SHIFT entry; each tick toggles sclk, so sclk first rises H cycles after entry.
REQ-016 SHALL change sdo only on a tick where sclk goes 1->0; sdo is therefore stable for H cycles before and after every sclk rise.
REQ-017 SHALL, on a falling tick with bit counter == WIDTH-1, enter LATCH with sclk=0; otherwise shift left, output the next bit and increment the bit counter.
REQ-018 SHALL hold latch=1 for exactly H cycles in LATCH, then return to IDLE with latch=0.
REQ-019 SHALL drive busy=1 from N+1 through N+(2*WIDTH+1)*H inclusive, and drive done=1, busy=0 and oe_n=0 at N+(2*WIDTH+1)*H+1.
REQ-020 SHALL, on write=1 while busy=1, store data in a one-deep buffer and set pending; a later write before start overwrites it (last wins); pending clears when the buffered frame starts.
REQ-021 SHALL start a pending frame on the first IDLE cycle after done, so busy is low for exactly one cycle between back-to-back frames.
REQ-022 SHALL hold sclk=0 and latch=0 in IDLE, and keep sdo at its last value there.
REQ-023 SHALL keep oe_n=0 after it first falls, until sclr.

Reset
REQ-024 SHALL, on sclr=1, set state IDLE, busy=0, done=0, sclk=0, sdo=0, latch=0, oe_n=1, pending=0, and clear the counters, shift register and buffer on the next edge.
REQ-025 SHALL abort a frame immediately on sclr mid-frame: no latch pulse and no done pulse are produced.
REQ-026 SHALL ignore a write asserted in the same cycle as sclr.
REQ-027 SHALL have no dependency on power-up register values beyond the first sclr.

Verification
REQ-028 SHALL cover: WIDTH=16, CLK_DIV=10, single write of 0xA5C3 -> 16 sclk rises with sdo 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; busy high 165 cycles; one latch pulse of 5 cycles; done then oe_n 1->0.
REQ-029 SHALL cover: write 0x0001 then, while busy, writes 0x1234 and 0x8000 -> second frame sends 0x8000 only; busy low exactly one cycle between frames; two done pulses.
REQ-030 SHALL cover: sclr at bit 7 of a frame -> next cycle sclk=0, latch=0, busy=0, oe_n=1; no done pulse; a new write of 0xFFFF completes normally.
REQ-031 SHALL cover: write and sclr in the same cycle -> remains IDLE; no sclk activity for 200 cycles.
REQ-032 SHALL cover: CLK_DIV=2, WIDTH=2, data 2'b10 -> sclk period 2 cycles; sdo 1 then 0; busy high 5 cycles.
REQ-033 SHALL cover: a scoreboard model of the 74HC595 (shift on sclk rise, capture on latch rise) whose parallel output equals every written word after its done pulse.
